// File: rtl/rv32i_pkg.sv
// -----------------------------------------------------------------------------
// rv32i_pkg
// Shared fetch-path definitions: response fault codes and the response record
// carried from instruction memory to decode.
// -----------------------------------------------------------------------------
package rv32i_pkg;

    localparam logic [1:0] FAULT_OK       = 2'b00;
    localparam logic [1:0] FAULT_MISALIGN = 2'b01;
    localparam logic [1:0] FAULT_RANGE    = 2'b10;

    localparam int RSP_INSTR_WIDTH = 32;
    localparam int RSP_ADDR_WIDTH  = 32;

    typedef struct packed {
        logic [RSP_INSTR_WIDTH-1:0] instr;
        logic [RSP_ADDR_WIDTH-1:0]  pc;
        logic [1:0]                 fault;
    } fetch_rsp_t;

endpackage

// File: rtl/fetch_rsp_fifo.sv
// -----------------------------------------------------------------------------
// fetch_rsp_fifo
// Synchronous first-word-fall-through FIFO for fetch responses.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   clear             synchronous flush of all entries (wins over push/pop)
//   push, push_data   write an entry (ignored when full and not popping)
//   pop               consume the head entry (ignored when empty)
//   pop_data          head entry, forced to zero while empty
//   valid             at least one entry is present
//   count             number of stored entries
// -----------------------------------------------------------------------------
module fetch_rsp_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             do_push_s;
    logic             do_pop_s;
    logic             not_empty_s;

    // Qualify push/pop against occupancy; a push into a full FIFO is legal only with a pop.
    always_comb begin
        not_empty_s = (count_r != {CNT_W{1'b0}});
        do_pop_s    = pop && not_empty_s;
        if (push && ((count_r < CNT_W'(DEPTH)) || do_pop_s)) begin
            do_push_s = 1'b1;
        end else begin
            do_push_s = 1'b0;
        end
    end

    // Entry storage; occupancy tracking decides what is visible, so no reset needed.
    always_ff @(posedge clk) begin
        if (do_push_s && !clear) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointers and occupancy counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else if (clear) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Head presentation; empty reads as all-zero so idle outputs are clean.
    always_comb begin
        valid = not_empty_s;
        count = count_r;
        if (not_empty_s) begin
            pop_data = mem_r[rd_ptr_r];
        end else begin
            pop_data = {WIDTH{1'b0}};
        end
    end

endmodule

// File: rtl/instr_mem_fetch_port.sv
// -----------------------------------------------------------------------------
// instr_mem_fetch_port
// Byte-addressed instruction memory with valid/ready request and response
// streams, one pipelined read stage, per-response fault flags, branch-redirect
// flush and a program-load write port.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   req_valid/req_ready/req_addr    fetch request (byte PC)
//   flush                           drop all in-flight and queued responses
//   rsp_valid/rsp_ready             response handshake
//   rsp_instr/rsp_pc/rsp_fault      response payload (fault: 00 ok, 01 misaligned, 10 range)
//   wr_en/wr_addr/wr_data           word write into the RAM (read-first)
// -----------------------------------------------------------------------------
module instr_mem_fetch_port
    import rv32i_pkg::*;
#(
    parameter int    INST_WIDTH = 32,
    parameter int    INST_DEPTH = 1024,
    parameter int    ADDR_WIDTH = 32,
    parameter int    RSP_DEPTH  = 2,
    parameter string INIT_FILE  = "instruction_init.hex"
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [ADDR_WIDTH-1:0]         req_addr,
    input  logic                          flush,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [INST_WIDTH-1:0]         rsp_instr,
    output logic [ADDR_WIDTH-1:0]         rsp_pc,
    output logic [1:0]                    rsp_fault,
    input  logic                          wr_en,
    input  logic [$clog2(INST_DEPTH)-1:0] wr_addr,
    input  logic [INST_WIDTH-1:0]         wr_data
);

    localparam int LSB     = $clog2(INST_WIDTH / 8);
    localparam int IDX_W   = $clog2(INST_DEPTH);
    localparam int ENTRY_W = INST_WIDTH + ADDR_WIDTH + 2;
    localparam int CNT_W   = $clog2(RSP_DEPTH) + 1;

    // Misaligned takes priority over out-of-range.
    function automatic logic [1:0] decode_fault(input logic [ADDR_WIDTH-1:0] addr);
        logic [1:0] fault;
        if (addr[LSB-1:0] != {LSB{1'b0}}) begin
            fault = FAULT_MISALIGN;
        end else if ((addr >> LSB) >= ADDR_WIDTH'(INST_DEPTH)) begin
            fault = FAULT_RANGE;
        end else begin
            fault = FAULT_OK;
        end
        return fault;
    endfunction

    logic [INST_WIDTH-1:0] ram_r [INST_DEPTH];
    logic [INST_WIDTH-1:0] ram_q_r;
    logic                  inflight_r;
    logic [ADDR_WIDTH-1:0] rd_pc_r;
    logic [1:0]            rd_fault_r;

    logic [IDX_W-1:0]      rd_idx_s;
    logic [1:0]            req_fault_s;
    logic                  accept_s;
    logic                  push_s;
    logic                  pop_s;
    logic [ENTRY_W-1:0]    push_data_s;
    logic [ENTRY_W-1:0]    head_s;
    logic                  head_valid_s;
    logic [CNT_W-1:0]      fifo_count_s;
    logic [CNT_W:0]        occupancy_s;

    // Request decode and acceptance. A pop this cycle frees a slot for the
    // request, which is what sustains one accept per cycle with a shallow FIFO.
    always_comb begin
        rd_idx_s    = req_addr[LSB +: IDX_W];
        req_fault_s = decode_fault(req_addr);
        pop_s       = head_valid_s && rsp_ready;
        occupancy_s = {1'b0, fifo_count_s} + (CNT_W+1)'(inflight_r) - (CNT_W+1)'(pop_s);
        if (flush) begin
            req_ready = 1'b0;
        end else if (occupancy_s < (CNT_W+1)'(RSP_DEPTH)) begin
            req_ready = 1'b1;
        end else begin
            req_ready = 1'b0;
        end
        accept_s = req_valid && req_ready;
    end

    // RAM write port; the read below samples the pre-write word (read-first).
    always_ff @(posedge clk) begin
        if (wr_en) begin
            ram_r[wr_addr] <= wr_data;
        end
    end

    // Synchronous RAM read, only enabled for requests that decoded cleanly.
    always_ff @(posedge clk) begin
        if (accept_s && (req_fault_s == FAULT_OK)) begin
            ram_q_r <= ram_r[rd_idx_s];
        end
    end

    // Read-stage bookkeeping: one in-flight slot carrying pc and fault.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_r <= 1'b0;
            rd_pc_r    <= {ADDR_WIDTH{1'b0}};
            rd_fault_r <= FAULT_OK;
        end else if (flush) begin
            inflight_r <= 1'b0;
        end else begin
            inflight_r <= accept_s;
            if (accept_s) begin
                rd_pc_r    <= req_addr;
                rd_fault_r <= req_fault_s;
            end
        end
    end

    // Read stage result enters the FIFO; faulted entries carry a zero word.
    always_comb begin
        push_s = inflight_r && !flush;
        if (rd_fault_r == FAULT_OK) begin
            push_data_s = {ram_q_r, rd_pc_r, rd_fault_r};
        end else begin
            push_data_s = {{INST_WIDTH{1'b0}}, rd_pc_r, rd_fault_r};
        end
    end

    fetch_rsp_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (flush),
        .push      (push_s),
        .push_data (push_data_s),
        .pop       (pop_s),
        .pop_data  (head_s),
        .valid     (head_valid_s),
        .count     (fifo_count_s)
    );

    // Response outputs come straight from the FIFO head registers.
    always_comb begin
        rsp_valid                        = head_valid_s;
        {rsp_instr, rsp_pc, rsp_fault}   = head_s;
    end

endmodule

// File: tb/tb_instr_mem_fetch_port.sv
module tb_instr_mem_fetch_port;
    import rv32i_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        flush;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_instr;
    logic [31:0] rsp_pc;
    logic [1:0]  rsp_fault;
    logic        wr_en;
    logic [9:0]  wr_addr;
    logic [31:0] wr_data;

    int check_cnt = 0;
    int pass_cnt  = 0;
    logic acc_flag;

    logic [31:0] model_mem [1024];
    fetch_rsp_t  exp_q [$];
    fetch_rsp_t  obs_q [$];
    fetch_rsp_t  o_e;
    fetch_rsp_t  e_e;

    instr_mem_fetch_port #(
        .INST_WIDTH (32),
        .INST_DEPTH (1024),
        .ADDR_WIDTH (32),
        .RSP_DEPTH  (2),
        .INIT_FILE  ("")
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .flush     (flush),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_instr (rsp_instr),
        .rsp_pc    (rsp_pc),
        .rsp_fault (rsp_fault),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic fetch_rsp_t model_rsp(input logic [31:0] a);
        fetch_rsp_t r;
        r.pc    = a;
        r.instr = 32'h0;
        if (a[1:0] != 2'b00) begin
            r.fault = FAULT_MISALIGN;
        end else if ((a >> 2) >= 32'd1024) begin
            r.fault = FAULT_RANGE;
        end else begin
            r.fault = FAULT_OK;
            r.instr = model_mem[a[11:2]];
        end
        return r;
    endfunction

    // One clock: record handshakes at the sampled inputs, then advance to next negedge.
    task automatic tick();
        fetch_rsp_t ob;
        #1;
        acc_flag = req_valid && req_ready;
        if (acc_flag) exp_q.push_back(model_rsp(req_addr));
        if (wr_en) model_mem[wr_addr] = wr_data;
        if (rsp_valid && rsp_ready) begin
            ob.instr = rsp_instr;
            ob.pc    = rsp_pc;
            ob.fault = rsp_fault;
            obs_q.push_back(ob);
        end
        if (flush) exp_q.delete();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        req_valid = 1'b0;
        req_addr  = 32'h0;
        flush     = 1'b0;
        rsp_ready = 1'b1;
        wr_en     = 1'b0;
        wr_addr   = 10'd0;
        wr_data   = 32'h0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        check_cnt++;
        if ({rsp_valid, rsp_instr, rsp_pc, rsp_fault} !== 67'd0)
            $display("FAIL reset_outputs: got valid=%b instr=%h pc=%h fault=%b, expected all zero",
                     rsp_valid, rsp_instr, rsp_pc, rsp_fault);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_cnt++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0)
            $display("FAIL reset_release: got req_ready=%b rsp_valid=%b, expected 1 and 0", req_ready, rsp_valid);
        else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_preload();
        for (int i = 0; i < 17; i++) begin
            wr_en   = 1'b1;
            wr_addr = (i == 16) ? 10'd1023 : 10'(i);
            if (i == 0)       wr_data = 32'h00500093;
            else if (i == 1)  wr_data = 32'h00A00113;
            else              wr_data = 32'h1000_0000 + 32'(i) * 32'h111;
            tick();
        end
        wr_en = 1'b0;
    endtask

    task automatic test_back_to_back();
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        req_addr  = 32'h0;
        tick();
        req_addr  = 32'h4;
        tick();
        req_valid = 1'b0;
        check_cnt++;
        if (rsp_valid !== 1'b1 || rsp_instr !== 32'h00500093 || rsp_pc !== 32'h0 || rsp_fault !== 2'b00)
            $display("FAIL b2b_first: got valid=%b instr=%h pc=%h fault=%b, expected 1 00500093 0 00",
                     rsp_valid, rsp_instr, rsp_pc, rsp_fault);
        else pass_cnt++;
        tick();
        check_cnt++;
        if (rsp_valid !== 1'b1 || rsp_instr !== 32'h00A00113 || rsp_pc !== 32'h4 || rsp_fault !== 2'b00)
            $display("FAIL b2b_second: got valid=%b instr=%h pc=%h fault=%b, expected 1 00a00113 4 00",
                     rsp_valid, rsp_instr, rsp_pc, rsp_fault);
        else pass_cnt++;
        for (int i = 0; i < 3; i++) tick();
        check_cnt++;
        if (obs_q.size() != exp_q.size())
            $display("FAIL b2b_count: got %0d responses, expected %0d", obs_q.size(), exp_q.size());
        else pass_cnt++;
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o_e = obs_q.pop_front();
            e_e = exp_q.pop_front();
            check_cnt++;
            if (o_e !== e_e)
                $display("FAIL b2b_rsp: got %h/%h/%b, expected %h/%h/%b",
                         o_e.instr, o_e.pc, o_e.fault, e_e.instr, e_e.pc, e_e.fault);
            else pass_cnt++;
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_throughput();
        int n_acc;
        n_acc     = 0;
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        req_addr  = 32'h0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (acc_flag) begin
                n_acc++;
                req_addr = req_addr + 32'd4;
            end
        end
        req_valid = 1'b0;
        check_cnt++;
        if (n_acc !== 8)
            $display("FAIL throughput_accepts: got %0d accepts in 8 cycles, expected 8", n_acc);
        else pass_cnt++;
        for (int i = 0; i < 4; i++) tick();
        check_cnt++;
        if (obs_q.size() != exp_q.size())
            $display("FAIL throughput_count: got %0d responses, expected %0d", obs_q.size(), exp_q.size());
        else pass_cnt++;
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o_e = obs_q.pop_front();
            e_e = exp_q.pop_front();
            check_cnt++;
            if (o_e !== e_e)
                $display("FAIL throughput_rsp: got %h/%h/%b, expected %h/%h/%b",
                         o_e.instr, o_e.pc, o_e.fault, e_e.instr, e_e.pc, e_e.fault);
            else pass_cnt++;
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_backpressure();
        int n_acc;
        logic [65:0] snap;
        n_acc     = 0;
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_addr  = 32'h10;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (acc_flag) begin
                n_acc++;
                req_addr = req_addr + 32'd4;
            end
        end
        #1;
        check_cnt++;
        if (req_ready !== 1'b0)
            $display("FAIL bp_ready: got req_ready=%b, expected 0", req_ready);
        else pass_cnt++;
        snap = {rsp_instr, rsp_pc, rsp_fault};
        for (int i = 0; i < 3; i++) begin
            tick();
            if (acc_flag) n_acc++;
        end
        check_cnt++;
        if (n_acc !== 2)
            $display("FAIL bp_accepts: got %0d accepts, expected 2", n_acc);
        else pass_cnt++;
        check_cnt++;
        if (rsp_valid !== 1'b1 || {rsp_instr, rsp_pc, rsp_fault} !== snap)
            $display("FAIL bp_stable: got valid=%b payload=%h, expected 1 %h",
                     rsp_valid, {rsp_instr, rsp_pc, rsp_fault}, snap);
        else pass_cnt++;
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        check_cnt++;
        if (obs_q.size() != 2 || exp_q.size() != 2)
            $display("FAIL bp_count: got %0d responses, expected %0d (2)", obs_q.size(), exp_q.size());
        else pass_cnt++;
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o_e = obs_q.pop_front();
            e_e = exp_q.pop_front();
            check_cnt++;
            if (o_e !== e_e)
                $display("FAIL bp_rsp: got %h/%h/%b, expected %h/%h/%b",
                         o_e.instr, o_e.pc, o_e.fault, e_e.instr, e_e.pc, e_e.fault);
            else pass_cnt++;
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_faults();
        logic [31:0] addrs [5];
        int k;
        addrs[0] = 32'h2;
        addrs[1] = 32'h1000;
        addrs[2] = 32'h1002;
        addrs[3] = 32'hFFC;
        addrs[4] = 32'h3;
        k         = 0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 20 && k < 5; i++) begin
            req_valid = 1'b1;
            req_addr  = addrs[k];
            tick();
            if (acc_flag) k++;
        end
        req_valid = 1'b0;
        check_cnt++;
        if (k !== 5)
            $display("FAIL fault_accepts: got %0d accepts, expected 5", k);
        else pass_cnt++;
        for (int i = 0; i < 4; i++) tick();
        check_cnt++;
        if (obs_q.size() != exp_q.size())
            $display("FAIL fault_count: got %0d responses, expected %0d", obs_q.size(), exp_q.size());
        else pass_cnt++;
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o_e = obs_q.pop_front();
            e_e = exp_q.pop_front();
            check_cnt++;
            if (o_e !== e_e)
                $display("FAIL fault_rsp: got %h/%h/%b, expected %h/%h/%b",
                         o_e.instr, o_e.pc, o_e.fault, e_e.instr, e_e.pc, e_e.fault);
            else pass_cnt++;
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_flush();
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_addr  = 32'h0;
        tick();
        req_addr  = 32'h4;
        tick();
        flush     = 1'b1;
        req_addr  = 32'h8;
        #1;
        check_cnt++;
        if (req_ready !== 1'b0)
            $display("FAIL flush_ready: got req_ready=%b during flush, expected 0", req_ready);
        else pass_cnt++;
        tick();
        flush     = 1'b0;
        rsp_ready = 1'b1;
        #1;
        check_cnt++;
        if (rsp_valid !== 1'b0)
            $display("FAIL flush_valid: got rsp_valid=%b after flush, expected 0", rsp_valid);
        else pass_cnt++;
        tick();
        check_cnt++;
        if (acc_flag !== 1'b1)
            $display("FAIL flush_resume: got accept=%b after flush, expected 1", acc_flag);
        else pass_cnt++;
        req_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check_cnt++;
        if (obs_q.size() != 1 || exp_q.size() != 1)
            $display("FAIL flush_count: got %0d responses, expected %0d (1)", obs_q.size(), exp_q.size());
        else pass_cnt++;
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o_e = obs_q.pop_front();
            e_e = exp_q.pop_front();
            check_cnt++;
            if (o_e !== e_e)
                $display("FAIL flush_rsp: got %h/%h/%b, expected %h/%h/%b",
                         o_e.instr, o_e.pc, o_e.fault, e_e.instr, e_e.pc, e_e.fault);
            else pass_cnt++;
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_write_read_first();
        logic [31:0] old_word;
        old_word  = model_mem[3];
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        req_addr  = 32'hC;
        wr_en     = 1'b1;
        wr_addr   = 10'd3;
        wr_data   = 32'hDEADBEEF;
        tick();
        wr_en     = 1'b0;
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check_cnt++;
        if (obs_q.size() != 2)
            $display("FAIL wr_count: got %0d responses, expected 2", obs_q.size());
        else pass_cnt++;
        if (obs_q.size() == 2) begin
            check_cnt++;
            if (obs_q[0].instr !== old_word || obs_q[1].instr !== 32'hDEADBEEF)
                $display("FAIL wr_read_first: got %h then %h, expected %h then deadbeef",
                         obs_q[0].instr, obs_q[1].instr, old_word);
            else pass_cnt++;
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o_e = obs_q.pop_front();
            e_e = exp_q.pop_front();
            check_cnt++;
            if (o_e !== e_e)
                $display("FAIL wr_rsp: got %h/%h/%b, expected %h/%h/%b",
                         o_e.instr, o_e.pc, o_e.fault, e_e.instr, e_e.pc, e_e.fault);
            else pass_cnt++;
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset_midop();
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_addr  = 32'h0;
        for (int i = 0; i < 4; i++) tick();
        check_cnt++;
        if (rsp_valid !== 1'b1)
            $display("FAIL rst_prefill: got rsp_valid=%b before reset, expected 1", rsp_valid);
        else pass_cnt++;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        #1;
        check_cnt++;
        if (rsp_valid !== 1'b0 || rsp_instr !== 32'h0 || rsp_pc !== 32'h0)
            $display("FAIL rst_immediate: got valid=%b instr=%h pc=%h, expected 0 0 0",
                     rsp_valid, rsp_instr, rsp_pc);
        else pass_cnt++;
        exp_q.delete();
        obs_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        #1;
        check_cnt++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0)
            $display("FAIL rst_release: got req_ready=%b rsp_valid=%b, expected 1 0", req_ready, rsp_valid);
        else pass_cnt++;
        for (int i = 0; i < 4; i++) tick();
        check_cnt++;
        if (obs_q.size() != 0)
            $display("FAIL rst_stale: got %0d responses after reset, expected 0", obs_q.size());
        else pass_cnt++;
        obs_q.delete();
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        test_reset();
        test_preload();
        test_back_to_back();
        test_throughput();
        test_backpressure();
        test_faults();
        test_flush();
        test_write_read_first();
        test_reset_midop();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
